// File: rtl/spi_tx_serializer_if.sv
// spi_tx_serializer_if
//   Bundles the FIFO read side and the SPI master pins of spi_tx_serializer.
//   master : serializer side (consumes enable/fifo_e/rx_data, drives the rest)
//   slave  : environment side (FIFO + SPI target + control)
// Signals:
//   enable    permits new byte fetches
//   fifo_e    FIFO empty flag
//   rx_data   FIFO read data, valid one cycle after rx_ready
//   rx_ready  one-cycle pop request
//   sclk/mosi/cs_n  SPI mode-0 master pins
//   busy      serializer not idle
//   byte_done one-cycle pulse per transmitted byte
//   tx_count  bytes transmitted since reset (wraps)
interface spi_tx_serializer_if;
  logic        enable;
  logic        fifo_e;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic        busy;
  logic        byte_done;
  logic [15:0] tx_count;

  modport master (
    input  enable, fifo_e, rx_data,
    output rx_ready, sclk, mosi, cs_n, busy, byte_done, tx_count
  );

  modport slave (
    output enable, fifo_e, rx_data,
    input  rx_ready, sclk, mosi, cs_n, busy, byte_done, tx_count
  );
endinterface

// File: rtl/spi_tx_serializer.sv
// spi_tx_serializer
//   Pops bytes from a FIFO read port and shifts them out as SPI mode-0 master
//   frames. cs_n stays low across back-to-back bytes while the FIFO has data
//   and is released CS_HOLD cycles after the frame ends (FIFO drained or
//   enable low).
// Parameters:
//   CLK_DIV  spi_clk cycles per sclk half-period (1..255)
//   CS_HOLD  spi_clk cycles of cs_n hold in HOLD before release (1..255)
// Ports:
//   spi_clk  sole clock, posedge
//   rst      synchronous active-high reset
//   bus      spi_tx_serializer_if.master (FIFO read side + SPI pins + status)
// Build option:
//   SPI_TX_LSB_FIRST_EN  when defined, bits go out LSB first (default MSB first)
module spi_tx_serializer #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_HOLD = 2
) (
  input  logic                       spi_clk,
  input  logic                       rst,
  spi_tx_serializer_if.master        bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, LOAD, SHIFT, NEXT, HOLD} state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD - 1);

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  hold_q, hold_d;
  logic        rx_ready_q, rx_ready_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic        busy_q, busy_d;
  logic        byte_done_q, byte_done_d;
  logic [15:0] tx_count_q, tx_count_d;

  logic        fetch;
  logic        first_bit;
  logic        next_bit;
  logic [7:0]  shifted;

  assign fetch = bus.enable && !bus.fifo_e;

`ifdef SPI_TX_LSB_FIRST_EN
  assign first_bit = shift_q[0];
  assign next_bit  = shift_q[1];
  assign shifted   = {1'b0, shift_q[7:1]};
`else
  assign first_bit = shift_q[7];
  assign next_bit  = shift_q[6];
  assign shifted   = {shift_q[6:0], 1'b0};
`endif

  // Every output is computed here as a next value and registered below.
  // rx_ready is raised on entry to REQ so the FIFO sees it during REQ;
  // the other per-state actions land on the state's closing edge.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    div_d       = div_q;
    hold_d      = hold_q;
    rx_ready_d  = 1'b0;
    sclk_d      = 1'b0;
    mosi_d      = mosi_q;
    cs_n_d      = cs_n_q;
    byte_done_d = 1'b0;
    tx_count_d  = tx_count_q;

    unique case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        if (fetch) begin
          state_d    = REQ;
          rx_ready_d = 1'b1;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        shift_d = bus.rx_data;
        state_d = LOAD;
      end
      LOAD: begin
        cs_n_d  = 1'b0;
        mosi_d  = first_bit;
        bit_d   = '0;
        div_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sclk_d = sclk_q;
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              byte_done_d = 1'b1;
              tx_count_d  = tx_count_q + 16'd1;
              state_d     = NEXT;
            end else begin
              shift_d = shifted;
              mosi_d  = next_bit;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      NEXT: begin
        if (fetch) begin
          state_d    = REQ;
          rx_ready_d = 1'b1;
        end else begin
          state_d = HOLD;
          hold_d  = '0;
        end
      end
      HOLD: begin
        if (hold_q == HOLD_LAST) begin
          cs_n_d  = 1'b1;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      div_q       <= '0;
      hold_q      <= '0;
      rx_ready_q  <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      byte_done_q <= 1'b0;
      tx_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      hold_q      <= hold_d;
      rx_ready_q  <= rx_ready_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_n_q      <= cs_n_d;
      busy_q      <= busy_d;
      byte_done_q <= byte_done_d;
      tx_count_q  <= tx_count_d;
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.sclk      = sclk_q;
  assign bus.mosi      = mosi_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.busy      = busy_q;
  assign bus.byte_done = byte_done_q;
  assign bus.tx_count  = tx_count_q;

endmodule
